// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-sample debounce and a
// four-state press FSM. Emits one registered clkpulse per press; define BTN_AUTOREPEAT_EN for auto-repeat.
module btn_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic clkpulse,
    output logic btn_level
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            s1;
    logic            s2;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic            press_commit;
    logic            release_commit;
    logic            level_nxt;
    logic            pulse_nxt;

    // Debounce FSM: the wait states count consecutive differing samples of s2;
    // any sample back at the stable level drops to the stable state and clears.
    always_comb begin
        state_nxt      = state;
        db_cnt_nxt     = '0;
        press_commit   = 1'b0;
        release_commit = 1'b0;
        unique case (state)
            IDLE: begin
                if (s2) begin
                    state_nxt  = PRESS_WAIT;
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt    = HELD;
                    press_commit = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s2) begin
                    state_nxt  = RELEASE_WAIT;
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_nxt = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt      = IDLE;
                    release_commit = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        level_nxt = btn_level;
        if (press_commit) begin
            level_nxt = 1'b1;
        end else if (release_commit) begin
            level_nxt = 1'b0;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX) + 1;
    localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

    logic [RP_W-1:0] rp_cnt;
    logic [RP_W-1:0] rp_cnt_nxt;
    logic            rp_first;
    logic            rp_first_nxt;
    logic            rp_fire;

    // Repeat timer keeps running through RELEASE_WAIT so a bouncy release does
    // not restart the cadence; the release commit cycle itself never fires.
    always_comb begin
        rp_cnt_nxt   = rp_cnt;
        rp_first_nxt = rp_first;
        rp_fire      = 1'b0;
        if (press_commit) begin
            rp_cnt_nxt   = '0;
            rp_first_nxt = 1'b1;
        end else if (state == HELD || state == RELEASE_WAIT) begin
            if (rp_cnt == (rp_first ? RD_LAST : RP_LAST)) begin
                rp_cnt_nxt   = '0;
                rp_first_nxt = 1'b0;
                rp_fire      = !release_commit;
            end else begin
                rp_cnt_nxt = rp_cnt + 1'b1;
            end
        end else begin
            rp_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rp_cnt   <= '0;
            rp_first <= 1'b0;
        end else begin
            rp_cnt   <= rp_cnt_nxt;
            rp_first <= rp_first_nxt;
        end
    end

    assign pulse_nxt = press_commit | rp_fire;
`else
    assign pulse_nxt = press_commit;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            state     <= IDLE;
            db_cnt    <= '0;
            btn_level <= 1'b0;
            clkpulse  <= 1'b0;
        end else begin
            s1        <= btn;
            s2        <= s1;
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            btn_level <= level_nxt;
            clkpulse  <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen: run-length reference model checked every cycle,
// plus directed scenarios with literal edge-count expectations.
module tb_btn_pulse_gen;

    localparam int D = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RD = 10;
    localparam int RP = 4;
`endif

    logic clk;
    logic rst_n;
    logic btn;
    logic clkpulse;
    logic btn_level;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES(D)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .clkpulse (clkpulse),
        .btn_level(btn_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: btn reaches the logic two edges late; a level change is
    // accepted after D consecutive samples that differ from the accepted level.
    bit m_s1, m_s2, m_lvl, m_pulse;
    int m_run;
`ifdef BTN_AUTOREPEAT_EN
    int m_since;
    bit m_first;
`endif

    always @(posedge clk) begin : ref_model
        automatic bit lvl = m_lvl;
        automatic bit pls = 1'b0;
        automatic bit cmt = 1'b0;
        automatic int run = m_run;
`ifdef BTN_AUTOREPEAT_EN
        automatic int since = m_since;
        automatic bit first = m_first;
`endif
        if (!rst_n) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_lvl <= 1'b0; m_pulse <= 1'b0; m_run <= 0;
`ifdef BTN_AUTOREPEAT_EN
            m_since <= 0; m_first <= 1'b0;
`endif
        end else begin
            if (m_s2 != lvl) begin
                run++;
                if (run == D) begin
                    lvl = m_s2;
                    run = 0;
                    cmt = 1'b1;
                    if (lvl) begin
                        pls = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        since = 0;
                        first = 1'b1;
`endif
                    end
                end
            end else begin
                run = 0;
            end
`ifdef BTN_AUTOREPEAT_EN
            if (lvl && !cmt) begin
                since++;
                if (since == (first ? RD : RP)) begin
                    pls   = 1'b1;
                    since = 0;
                    first = 1'b0;
                end
            end
            m_since <= since;
            m_first <= first;
`endif
            m_lvl   <= lvl;
            m_run   <= run;
            m_pulse <= pls;
            m_s2    <= m_s1;
            m_s1    <= btn;
        end
    end

    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_clkpulse", clkpulse, m_pulse);
            check("model_btn_level", btn_level, m_lvl);
            check("pulse_not_back_to_back", clkpulse & prev_pulse, 1'b0);
        end
        prev_pulse <= clkpulse;
    end

    // Drive btn for one edge and check outputs just after that edge.
    task automatic step_chk(input logic b, input string name, input logic ep, input logic el);
        @(negedge clk);
        btn = b;
        @(posedge clk);
        #1;
        check({name, "_pulse"}, clkpulse, ep);
        check({name, "_level"}, btn_level, el);
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        btn = b;
    endtask

    function automatic logic rel_pulse(input int k);
`ifdef BTN_AUTOREPEAT_EN
        return (k == 1 || k == 5);
`else
        return (k < 0);
`endif
    endfunction

    initial begin
        int seg;
        logic target;
        btn   = 1'b0;
        rst_n = 1'b0;
        seg   = 0;
        target = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pulse", clkpulse, 1'b0);
        check("reset_level", btn_level, 1'b0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);

        for (int k = 1; k <= 15; k++) step_chk(1'b1, "clean_press", k == 6, k >= 6);
        for (int k = 1; k <= 12; k++) step_chk(1'b0, "release", rel_pulse(k), k < 6);

        for (int k = 1; k <= 18; k++) step_chk(k <= 3, "glitch", 1'b0, 1'b0);

        for (int k = 1; k <= 25; k++) begin
            automatic logic b = (k <= 15) ? (((k - 1) / 2) % 2 == 0) : 1'b1;
            step_chk(b, "bounce", k == 21, k >= 21);
        end
        repeat (12) step(1'b0);

        @(negedge clk);
        btn   = 1'b1;
        rst_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check("held_in_reset_pulse", clkpulse, 1'b0);
            check("held_in_reset_level", btn_level, 1'b0);
            if (k < 5) @(negedge clk);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) step_chk(1'b1, "held_reset_press", k == 6, k >= 6);
        repeat (12) step(1'b0);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (seg == 0) begin
                target = 1'($urandom_range(0, 1));
                seg = $urandom_range(1, 3);
                if ($urandom_range(0, 2) == 0) seg += $urandom_range(5, 40);
            end
            seg--;
            btn   = target;
            rst_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        btn   = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
